// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arm/disarm control, near-distance qualification and alarm beep/cooldown sequencing.
module alarm_sequencer #(
    parameter int THRESH      = 100,
    parameter int CONFIRM     = 4,
    parameter int EXIT_TICKS  = 1000,
    parameter int BEEP_ON     = 50,
    parameter int BEEP_OFF    = 50,
    parameter int ALARM_TICKS = 5000,
    parameter int COOL_TICKS  = 500,
    parameter int TW          = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic       arm,
    input  logic       disarm,
    input  logic       dist_valid,
    input  logic [7:0] distance,
    output logic       snd_en,
    output logic       armed,
    output logic       alarm,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ALARM    = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [8:0]    TH      = 9'(THRESH);
    localparam logic [CW-1:0] CONF    = CW'(CONFIRM);
    localparam logic [TW-1:0] EXIT_T  = TW'(EXIT_TICKS);
    localparam logic [TW-1:0] ON_T    = TW'(BEEP_ON);
    localparam logic [TW-1:0] OFF_T   = TW'(BEEP_OFF);
    localparam logic [TW-1:0] ALARM_T = TW'(ALARM_TICKS);
    localparam logic [TW-1:0] COOL_T  = TW'(COOL_TICKS);

    state_t        cur, nxt;
    logic [TW-1:0] timer, timer_n, beep, beep_n;
    logic [CW-1:0] count, count_n;
    logic          phase, phase_n, snd_n, near;

    assign near  = {1'b0, distance} < TH;
    assign state = cur;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cur    <= DISARMED;
            timer  <= '0;
            beep   <= '0;
            count  <= '0;
            phase  <= 1'b0;
            snd_en <= 1'b0;
            armed  <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            cur    <= nxt;
            timer  <= timer_n;
            beep   <= beep_n;
            count  <= count_n;
            phase  <= phase_n;
            snd_en <= snd_n;
            armed  <= (nxt == ARMED) || (nxt == ALARM) || (nxt == COOLDOWN);
            alarm  <= nxt == ALARM;
        end
    end

    always_comb begin
        nxt     = cur;
        timer_n = timer;
        beep_n  = beep;
        count_n = count;
        phase_n = phase;
        snd_n   = 1'b0;
        case (cur)
            DISARMED: if (arm) begin
                nxt     = ARMING;
                timer_n = '0;
            end
            ARMING: if (tick) begin
                timer_n = timer + 1'b1;
                if (timer_n == EXIT_T) begin
                    nxt     = ARMED;
                    timer_n = '0;
                    count_n = '0;
                end
            end
            ARMED: if (dist_valid) begin
                count_n = near ? count + 1'b1 : '0;
                if (near && count_n == CONF) begin
                    nxt     = ALARM;
                    timer_n = '0;
                    beep_n  = '0;
                    phase_n = 1'b1;
                    snd_n   = 1'b1;
                end
            end
            ALARM: begin
                snd_n = phase;
                if (tick) begin
                    timer_n = timer + 1'b1;
                    beep_n  = beep + 1'b1;
                    // phase flips on the tick that completes the current half-period
                    if (beep_n == (phase ? ON_T : OFF_T)) begin
                        phase_n = !phase;
                        beep_n  = '0;
                    end
                    snd_n = phase_n;
                    if (timer_n == ALARM_T) begin
                        nxt     = COOLDOWN;
                        timer_n = '0;
                        snd_n   = 1'b0;
                    end
                end
            end
            COOLDOWN: if (tick) begin
                timer_n = timer + 1'b1;
                if (timer_n == COOL_T) begin
                    nxt     = ARMED;
                    timer_n = '0;
                    count_n = '0;
                end
            end
            default: nxt = DISARMED;
        endcase
        if (disarm) begin
            nxt     = DISARMED;
            timer_n = '0;
            beep_n  = '0;
            count_n = '0;
            phase_n = 1'b0;
            snd_n   = 1'b0;
        end
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed checks of arming, confirmation, beep cadence, cooldown, disarm and reset.
module tb_alarm_sequencer;
    logic       CLK = 1'b0;
    logic       RST, tick, arm, disarm, dist_valid;
    logic [7:0] distance;
    logic       snd_en, armed, alarm;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;
    logic [11:0] pat = 12'b110001100011;

    alarm_sequencer #(
        .THRESH(100), .CONFIRM(4), .EXIT_TICKS(4), .BEEP_ON(2), .BEEP_OFF(3),
        .ALARM_TICKS(12), .COOL_TICKS(3), .TW(16)
    ) dut (
        .CLK(CLK), .RST(RST), .tick(tick), .arm(arm), .disarm(disarm),
        .dist_valid(dist_valid), .distance(distance),
        .snd_en(snd_en), .armed(armed), .alarm(alarm), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic sample(input logic [7:0] d);
        dist_valid = 1'b1;
        distance   = d;
        step();
        dist_valid = 1'b0;
    endtask

    task automatic arm_up();
        tick = 1'b0;
        arm  = 1'b1;
        step();
        arm  = 1'b0;
        tick = 1'b1;
        step(4);
        tick = 1'b0;
    endtask

    initial begin
        RST = 1'b0; tick = 1'b0; arm = 1'b0; disarm = 1'b0; dist_valid = 1'b0; distance = 8'd0;
        step(2);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_armed", 16'(armed), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        chk("rst_snd", 16'(snd_en), 16'd0);
        RST = 1'b1;
        // arm and disarm together: disarm wins
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        chk("arm_disarm_state", 16'(state), 16'd0);
        // exit delay of four ticks
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arming_state", 16'(state), 16'd1);
        tick = 1'b1;
        step(3);
        chk("arming_3ticks", 16'(state), 16'd1);
        chk("arming_armed", 16'(armed), 16'd0);
        step();
        chk("armed_state", 16'(state), 16'd2);
        chk("armed_flag", 16'(armed), 16'd1);
        tick = 1'b0;
        // confirmation run broken by a far sample
        sample(8'd50); sample(8'd60); sample(8'd120);
        sample(8'd50); sample(8'd50); sample(8'd50);
        chk("confirm_6th", 16'(alarm), 16'd0);
        sample(8'd50);
        chk("confirm_7th", 16'(alarm), 16'd1);
        chk("alarm_state", 16'(state), 16'd3);
        // beep cadence over the whole alarm
        tick = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("beep_%0d", i), 16'(snd_en), 16'(pat[11-i]));
            step();
        end
        chk("cool_state", 16'(state), 16'd4);
        chk("cool_snd", 16'(snd_en), 16'd0);
        chk("cool_armed", 16'(armed), 16'd1);
        chk("cool_alarm", 16'(alarm), 16'd0);
        step(2);
        chk("cool_2ticks", 16'(state), 16'd4);
        step();
        chk("rearmed_state", 16'(state), 16'd2);
        tick = 1'b0;
        // count restarts after cooldown
        sample(8'd10);
        chk("one_near", 16'(alarm), 16'd0);
        sample(8'd10); sample(8'd10);
        chk("three_near", 16'(alarm), 16'd0);
        sample(8'd10);
        chk("four_near", 16'(alarm), 16'd1);
        tick = 1'b1;
        step(2);
        chk("mid_alarm_snd", 16'(snd_en), 16'd0);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        chk("disarm_state", 16'(state), 16'd0);
        chk("disarm_snd", 16'(snd_en), 16'd0);
        chk("disarm_armed", 16'(armed), 16'd0);
        // threshold boundary: 100 is not near
        arm_up();
        chk("rearm2", 16'(state), 16'd2);
        sample(8'd99); sample(8'd99); sample(8'd99); sample(8'd100);
        chk("thresh_100", 16'(alarm), 16'd0);
        sample(8'd99); sample(8'd99); sample(8'd99);
        chk("thresh_3x99", 16'(alarm), 16'd0);
        sample(8'd99);
        chk("thresh_4x99", 16'(alarm), 16'd1);
        chk("thresh_snd", 16'(snd_en), 16'd1);
        // reset during alarm with activity on inputs
        tick = 1'b1; dist_valid = 1'b1; distance = 8'd10; RST = 1'b0;
        step();
        chk("rst_alarm_state", 16'(state), 16'd0);
        chk("rst_alarm_snd", 16'(snd_en), 16'd0);
        chk("rst_alarm_armed", 16'(armed), 16'd0);
        chk("rst_alarm_alarm", 16'(alarm), 16'd0);
        RST = 1'b1; tick = 1'b0; dist_valid = 1'b0;
        step();
        chk("post_rst_state", 16'(state), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
